clock_set_controller: RTL and testbench

Time-setting sequencer for the electronic clock datapath. It takes debounced button pulses and edits shadow copies of hour and minute. It then commits them to the clock counters with a two-beat write (wen/waddr/wdata). While editing, it drives the values and per-digit blink masks toward the BCD/seven-segment path. Sits between the debounce circuits, the 1 Hz tick source and the clock register block.

---
 rtl/clock_set_pkg.sv | 25 ++
 rtl/wrap_counter_field.sv | 54 +++++
 rtl/clock_set_controller.sv | 157 +++++++++++++++
 tb/tb_clock_set_controller.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/clock_set_pkg.sv
// +--------------------------------------------------------------------+
// | clock_set_pkg: shared state encoding, write addresses and blink      |
// | masks for the clock time-setting sequencer.                          |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

package clock_set_pkg;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] EDIT_HR  = 3'd1;
    localparam logic [2:0] EDIT_MIN = 3'd2;
    localparam logic [2:0] WR_HR    = 3'd3;
    localparam logic [2:0] WR_MIN   = 3'd4;

    localparam logic WADDR_HOUR = 1'b0;
    localparam logic WADDR_MIN  = 1'b1;

    localparam logic [3:0] BLINK_NONE = 4'b0000;
    localparam logic [3:0] BLINK_HOUR = 4'b1100;
    localparam logic [3:0] BLINK_MIN  = 4'b0011;

endpackage

`default_nettype wire

// File: rtl/wrap_counter_field.sv
// +--------------------------------------------------------------------+
// | wrap_counter_field: 8-bit editable field with load and wrapping      |
// | increment (decrement when CLOCK_SET_DEC_EN is defined).              |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module wrap_counter_field #(
    parameter int unsigned MAX = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       inc,
`ifdef CLOCK_SET_DEC_EN
    input  logic       dec,
`endif
    output logic [7:0] value
);

    localparam logic [7:0] C_MAX = 8'(MAX);

    logic [7:0] r_value;
    logic       w_do_inc;
    logic       w_do_dec;

`ifdef CLOCK_SET_DEC_EN
    // Opposing requests cancel out.
    assign w_do_inc = inc & ~dec;
    assign w_do_dec = dec & ~inc;
`else
    assign w_do_inc = inc;
    assign w_do_dec = 1'b0;
`endif

    // Out-of-range loaded values wrap on the next increment.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_value <= 8'd0;
        end else if (load) begin
            r_value <= load_val;
        end else if (w_do_inc) begin
            r_value <= (r_value >= C_MAX) ? 8'd0 : r_value + 8'd1;
        end else if (w_do_dec) begin
            r_value <= (r_value == 8'd0) ? C_MAX : r_value - 8'd1;
        end
    end

    assign value = r_value;

endmodule

`default_nettype wire

// File: rtl/clock_set_controller.sv
// +--------------------------------------------------------------------+
// | clock_set_controller: edits shadow hour/minute from button pulses   |
// | and commits them as a two-beat write. Option: CLOCK_SET_DEC_EN.     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module clock_set_controller
    import clock_set_pkg::*;
#(
    parameter int unsigned HOUR_MAX      = 23,
    parameter int unsigned MIN_MAX       = 59,
    parameter int unsigned TIMEOUT_TICKS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_set,
    input  logic       btn_inc,
`ifdef CLOCK_SET_DEC_EN
    input  logic       btn_dec,
`endif
    input  logic [7:0] cur_hour,
    input  logic [7:0] cur_min,
    output logic       wen,
    output logic       waddr,
    output logic [7:0] wdata,
    output logic       editing,
    output logic [7:0] disp_hour,
    output logic [7:0] disp_min,
    output logic [3:0] blink_mask
);

    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT_TICKS);

    logic [2:0] r_state, w_state_nxt;
    logic [7:0] r_timeout, w_timeout_nxt;
    logic       r_phase, w_phase_nxt;
    logic       r_wen, r_waddr, r_editing;
    logic [7:0] r_wdata;
    logic [3:0] r_blink;
    logic [7:0] w_shadow_hour, w_shadow_min;
    logic       w_in_edit, w_load, w_btn_any, w_inc_ok, w_dec_ok, w_edit_change;

`ifdef CLOCK_SET_DEC_EN
    assign w_btn_any = btn_set | btn_inc | btn_dec;
    assign w_dec_ok  = btn_dec & ~btn_set;
`else
    assign w_btn_any = btn_set | btn_inc;
    assign w_dec_ok  = 1'b0;
`endif

    assign w_in_edit     = (r_state == EDIT_HR) || (r_state == EDIT_MIN);
    assign w_load        = (r_state == IDLE) && btn_set;
    assign w_inc_ok      = btn_inc & ~btn_set;
    assign w_edit_change = w_in_edit & (w_inc_ok | w_dec_ok);

    wrap_counter_field #(.MAX(HOUR_MAX)) u_hour (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .load_val (cur_hour),
        .inc      ((r_state == EDIT_HR) && w_inc_ok),
`ifdef CLOCK_SET_DEC_EN
        .dec      ((r_state == EDIT_HR) && w_dec_ok),
`endif
        .value    (w_shadow_hour)
    );

    wrap_counter_field #(.MAX(MIN_MAX)) u_min (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .load_val (cur_min),
        .inc      ((r_state == EDIT_MIN) && w_inc_ok),
`ifdef CLOCK_SET_DEC_EN
        .dec      ((r_state == EDIT_MIN) && w_dec_ok),
`endif
        .value    (w_shadow_min)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_timeout_nxt = r_timeout;
        w_phase_nxt   = r_phase;
        case (r_state)
            IDLE: begin
                if (btn_set) begin
                    w_state_nxt   = EDIT_HR;
                    w_timeout_nxt = 8'd0;
                    w_phase_nxt   = 1'b1;
                end
            end
            EDIT_HR, EDIT_MIN: begin
                if (tick) begin
                    w_phase_nxt = ~r_phase;
                end
                if (w_edit_change) begin
                    w_phase_nxt = 1'b0;
                end
                // A button in the same cycle as the terminal tick cancels the abort.
                if (w_btn_any) begin
                    w_timeout_nxt = 8'd0;
                end else if (tick) begin
                    if (r_timeout + 8'd1 == C_TIMEOUT) begin
                        w_state_nxt   = IDLE;
                        w_timeout_nxt = 8'd0;
                    end else begin
                        w_timeout_nxt = r_timeout + 8'd1;
                    end
                end
                if (btn_set) begin
                    w_state_nxt = (r_state == EDIT_HR) ? EDIT_MIN : WR_HR;
                end
            end
            WR_HR:   w_state_nxt = WR_MIN;
            WR_MIN:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the current state, so each lags state entry by a cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_timeout <= 8'd0;
            r_phase   <= 1'b0;
            r_wen     <= 1'b0;
            r_waddr   <= WADDR_HOUR;
            r_wdata   <= 8'd0;
            r_editing <= 1'b0;
            r_blink   <= BLINK_NONE;
        end else begin
            r_state   <= w_state_nxt;
            r_timeout <= w_timeout_nxt;
            r_phase   <= w_phase_nxt;
            r_wen     <= (r_state == WR_HR) || (r_state == WR_MIN);
            r_waddr   <= (r_state == WR_MIN) ? WADDR_MIN : WADDR_HOUR;
            r_wdata   <= (r_state == WR_HR)  ? w_shadow_hour :
                         (r_state == WR_MIN) ? w_shadow_min  : 8'd0;
            r_editing <= (r_state != IDLE);
            r_blink   <= ((r_state == EDIT_HR)  && r_phase) ? BLINK_HOUR :
                         ((r_state == EDIT_MIN) && r_phase) ? BLINK_MIN  : BLINK_NONE;
        end
    end

    assign wen        = r_wen;
    assign waddr      = r_waddr;
    assign wdata      = r_wdata;
    assign editing    = r_editing;
    assign blink_mask = r_blink;
    assign disp_hour  = r_editing ? w_shadow_hour : cur_hour;
    assign disp_min   = r_editing ? w_shadow_min  : cur_min;

endmodule

`default_nettype wire

// File: tb/tb_clock_set_controller.sv
// +--------------------------------------------------------------------+
// | tb_clock_set_controller: scoreboard bench for clock_set_controller. |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_clock_set_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick, btn_set, btn_inc;
`ifdef CLOCK_SET_DEC_EN
    logic       btn_dec;
`endif
    logic [7:0] cur_hour, cur_min;
    logic       wen, waddr, editing;
    logic [7:0] wdata, disp_hour, disp_min;
    logic [3:0] blink_mask;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [8:0] exp_q[$];
    int         wen_cyc[$];
    int         wen_before;
    logic       phase;

    clock_set_controller dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .btn_set    (btn_set),
        .btn_inc    (btn_inc),
`ifdef CLOCK_SET_DEC_EN
        .btn_dec    (btn_dec),
`endif
        .cur_hour   (cur_hour),
        .cur_min    (cur_min),
        .wen        (wen),
        .waddr      (waddr),
        .wdata      (wdata),
        .editing    (editing),
        .disp_hour  (disp_hour),
        .disp_min   (disp_min),
        .blink_mask (blink_mask)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge: apply pulses for one rising edge, then release them.
    task automatic step(input logic s, input logic i, input logic t);
        btn_set = s;
        btn_inc = i;
        tick    = t;
        @(negedge clk);
        btn_set = 1'b0;
        btn_inc = 1'b0;
        tick    = 1'b0;
    endtask

`ifdef CLOCK_SET_DEC_EN
    task automatic step_dec(input logic i);
        btn_dec = 1'b1;
        btn_inc = i;
        @(negedge clk);
        btn_dec = 1'b0;
        btn_inc = 1'b0;
    endtask
`endif

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    // Write-beat scoreboard: every wen cycle must match the next queued {waddr, wdata}.
    always @(negedge clk) begin
        if (wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("wen_spurious", 32'd1, 32'd0);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check_val("waddr", 32'(waddr), 32'(e[8]));
                check_val("wdata", 32'(wdata), 32'(e[7:0]));
            end
            wen_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; tick = 1'b0; btn_set = 1'b0; btn_inc = 1'b0;
`ifdef CLOCK_SET_DEC_EN
        btn_dec = 1'b0;
`endif
        cur_hour = 8'd23; cur_min = 8'd58;
        @(negedge clk);
        @(negedge clk);
        check_val("rst_wen", 32'(wen), 32'd0);
        check_val("rst_waddr", 32'(waddr), 32'd0);
        check_val("rst_wdata", 32'(wdata), 32'd0);
        check_val("rst_editing", 32'(editing), 32'd0);
        check_val("rst_blink", 32'(blink_mask), 32'd0);
        check_val("rst_disp_hour", 32'(disp_hour), 32'd23);
        reset = 1'b1;
        idle(1);

        // Full edit with wrap on both fields
        step(1, 0, 0);
        idle(1);
        check_val("edit_editing", 32'(editing), 32'd1);
        check_val("edit_blink_hr", 32'(blink_mask), 32'hC);
        step(0, 1, 0);
        step(1, 0, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        check_val("wrap_hour", 32'(disp_hour), 32'd0);
        check_val("wrap_min", 32'(disp_min), 32'd0);
        wen_before = wen_cyc.size();
        exp_q.push_back({1'b0, 8'd0});
        exp_q.push_back({1'b1, 8'd0});
        step(1, 0, 0);
        idle(4);
        check_val("commit_beats", 32'(wen_cyc.size() - wen_before), 32'd2);
        if (wen_cyc.size() >= 2)
            check_val("commit_b2b", 32'(wen_cyc[$] - wen_cyc[$-1]), 32'd1);
        check_val("commit_editing", 32'(editing), 32'd0);

        // Timeout after 10 idle ticks, no write
        cur_hour = 8'd5; cur_min = 8'd7;
        wen_before = wen_cyc.size();
        step(1, 0, 0);
        repeat (9) step(0, 0, 1);
        idle(1);
        check_val("to_9_editing", 32'(editing), 32'd1);
        step(0, 0, 1);
        idle(1);
        check_val("to_editing", 32'(editing), 32'd0);
        check_val("to_disp_hour", 32'(disp_hour), 32'd5);
        check_val("to_no_wen", 32'(wen_cyc.size() - wen_before), 32'd0);

        // Button on the terminal tick cancels the abort and clears the counter
        step(1, 0, 0);
        repeat (9) step(0, 0, 1);
        step(0, 1, 1);
        idle(1);
        check_val("race_editing", 32'(editing), 32'd1);
        check_val("race_hour", 32'(disp_hour), 32'd6);
        repeat (9) step(0, 0, 1);
        idle(1);
        check_val("race_cleared", 32'(editing), 32'd1);
        step(0, 0, 1);
        idle(1);
        check_val("race_abort", 32'(editing), 32'd0);

        // btn_set beats btn_inc; then blink sequence in EDIT_MIN
        step(1, 0, 0);
        step(1, 1, 0);
        idle(1);
        check_val("setinc_hour", 32'(disp_hour), 32'd5);
        check_val("setinc_blink", 32'(blink_mask), 32'h3);
        step(0, 1, 0);
        check_val("min_inc", 32'(disp_min), 32'd8);
        idle(1);
        phase = 1'b0;
        check_val("blink_after_inc", 32'(blink_mask), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1);
            phase = ~phase;
            idle(1);
            check_val("blink_tick", 32'(blink_mask), phase ? 32'h3 : 32'h0);
        end
        // Commit 5:08, then reset lands between the two beats
        exp_q.push_back({1'b0, 8'd5});
        step(1, 0, 0);
        idle(1);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        check_val("rst_mid_wen", 32'(wen), 32'd0);
        check_val("rst_mid_editing", 32'(editing), 32'd0);
        idle(3);

`ifdef CLOCK_SET_DEC_EN
        cur_hour = 8'd0; cur_min = 8'd0;
        step(1, 0, 0);
        step_dec(1'b0);
        idle(1);
        check_val("dec_hour", 32'(disp_hour), 32'd23);
        step(1, 0, 0);
        step_dec(1'b0);
        check_val("dec_min", 32'(disp_min), 32'd59);
        step_dec(1'b1);
        check_val("incdec_min", 32'(disp_min), 32'd59);
        exp_q.push_back({1'b0, 8'd23});
        exp_q.push_back({1'b1, 8'd59});
        step(1, 0, 0);
        idle(4);
`endif

        check_val("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
